// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache/memory arbiter
//
// Contents:
//   CACHE_CHUNKS  2-byte chunks per cache block
//   MEM_LATENCY   read latency of the shared main memory, in cycles
//   addr_t        16-bit memory/chunk address
//   arb_state_t   arbiter FSM state encoding
package cache_pkg;

   localparam int CACHE_CHUNKS = 8;
   localparam int MEM_LATENCY  = 4;

   typedef logic [15:0] addr_t;

   typedef enum logic [2:0] {
      ST_DRAIN  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_IFILL  = 3'd2,
      ST_DFILL  = 3'd3,
      ST_DWRITE = 3'd4
   } arb_state_t;

endpackage

// File: rtl/fill_beat_counter.sv
// rtl/fill_beat_counter.sv - issue/return chunk counting for one block fill
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   active       a block fill currently owns memory
//   beat         memory read data valid this cycle
//   issue_open   fill still has chunk reads left to issue this cycle
//   done         this beat is the last return of the block
module fill_beat_counter #(
   parameter int CHUNKS = cache_pkg::CACHE_CHUNKS
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic beat,
   output logic issue_open,
   output logic done
);

   localparam int CW = $clog2(CHUNKS + 1);
   localparam logic [CW-1:0] FULL = CW'(CHUNKS);
   localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

   logic [CW-1:0] issued;
   logic [CW-1:0] returned;

   assign issue_open = active && (issued < FULL);
   assign done       = active && beat && (returned == LAST);

   // Counters clear whenever no fill is running and on the final beat, so
   // a back-to-back fill starts from zero. Both saturate at CHUNKS.
   always_ff @(posedge clk) begin
      if (rst || !active || done) begin
         issued   <= '0;
         returned <= '0;
      end else begin
         if (issue_open)
            issued <= issued + 1'b1;
         if (beat && (returned < FULL))
            returned <= returned + 1'b1;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shared main-memory arbiter for I/D fills and D stores
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   icache_miss/icache_addr    I-cache fill request and chunk address
//   dcache_miss/dcache_addr    D-cache fill request and chunk address
//   dcache_wr/_wr_addr/_wr_data  D-cache write-through store
//   icache_grant/dcache_grant  fill ownership of memory
//   dcache_wr_done             one-cycle store acknowledge
//   icache_data_valid/dcache_data_valid  read returns routed to the owner
//   mem_enable/mem_wr/mem_addr/mem_data_in  memory request port
//   mem_data_valid             memory read data valid
// Build option: CACHE_ARB_ROUND_ROBIN_EN alternates contested fills.
module cache_mem_arbiter #(
   parameter int MEM_LATENCY = cache_pkg::MEM_LATENCY,
   parameter int CHUNKS      = cache_pkg::CACHE_CHUNKS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_miss,
   input  logic [15:0] icache_addr,
   input  logic        dcache_miss,
   input  logic [15:0] dcache_addr,
   input  logic        dcache_wr,
   input  logic [15:0] dcache_wr_addr,
   input  logic [15:0] dcache_wr_data,
   output logic        icache_grant,
   output logic        dcache_grant,
   output logic        dcache_wr_done,
   output logic        icache_data_valid,
   output logic        dcache_data_valid,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic        mem_data_valid
);

   import cache_pkg::*;

   localparam int DW = $clog2(MEM_LATENCY + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(MEM_LATENCY - 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [DW-1:0] drain_cnt;
   logic          fill_active;
   logic          issue_open;
   logic          fill_done;
   logic          pick_dfill;
   addr_t         fill_addr;

   assign fill_active = (state == ST_IFILL) || (state == ST_DFILL);

   fill_beat_counter #(
      .CHUNKS(CHUNKS)
   ) u_beats (
      .clk       (clk),
      .rst       (rst),
      .active    (fill_active),
      .beat      (mem_data_valid),
      .issue_open(issue_open),
      .done      (fill_done)
   );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   // 0: I-cache was served by the last fill, so the D-cache wins a tie.
   logic last_served_d;

   assign pick_dfill = dcache_miss && (!icache_miss || !last_served_d);

   always_ff @(posedge clk) begin
      if (rst)
         last_served_d <= 1'b0;
      else if (state == ST_IDLE && state_nxt == ST_DFILL)
         last_served_d <= 1'b1;
      else if (state == ST_IDLE && state_nxt == ST_IFILL)
         last_served_d <= 1'b0;
   end
`else
   assign pick_dfill = dcache_miss;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (dcache_wr)        state_nxt = ST_DWRITE;
            else if (pick_dfill)  state_nxt = ST_DFILL;
            else if (icache_miss) state_nxt = ST_IFILL;
         end
         ST_IFILL,
         ST_DFILL:  if (fill_done) state_nxt = ST_IDLE;
         ST_DWRITE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_DRAIN;
      endcase
   end

   // DRAIN outlasts any read issued before reset, so stale returns land
   // while nothing is granted and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_DRAIN;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      end
   end

   assign icache_grant      = (state == ST_IFILL);
   assign dcache_grant      = (state == ST_DFILL);
   assign dcache_wr_done    = (state == ST_DWRITE);
   assign icache_data_valid = icache_grant && mem_data_valid;
   assign dcache_data_valid = dcache_grant && mem_data_valid;
   assign fill_addr         = icache_grant ? icache_addr : dcache_addr;

   always_comb begin
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      if (state == ST_DWRITE) begin
         mem_enable  = 1'b1;
         mem_wr      = 1'b1;
         mem_addr    = dcache_wr_addr;
         mem_data_in = dcache_wr_data;
      end else if (issue_open) begin
         mem_enable = 1'b1;
         mem_addr   = fill_addr;
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

   localparam int LAT = 4;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        icache_miss, dcache_miss, dcache_wr, mem_data_valid;
   logic [15:0] icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data;
   logic        icache_grant, dcache_grant, dcache_wr_done;
   logic        icache_data_valid, dcache_data_valid;
   logic        mem_enable, mem_wr;
   logic [15:0] mem_addr, mem_data_in;

   acc_t exp_q[$];
   int   ret_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   n_valid[2];
   int   beat_first[2];
   int   beat_last[2];
   int   n_wr_done = 0;
   bit   last_d = 1'b0;
   logic s_igrant, s_dgrant, s_done, s_wr, s_ival, s_dval;
   logic [38:0] s_vec;

   always #5 clk = ~clk;

   cache_mem_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .icache_miss      (icache_miss),
      .icache_addr      (icache_addr),
      .dcache_miss      (dcache_miss),
      .dcache_addr      (dcache_addr),
      .dcache_wr        (dcache_wr),
      .dcache_wr_addr   (dcache_wr_addr),
      .dcache_wr_data   (dcache_wr_data),
      .icache_grant     (icache_grant),
      .dcache_grant     (dcache_grant),
      .dcache_wr_done   (dcache_wr_done),
      .icache_data_valid(icache_data_valid),
      .dcache_data_valid(dcache_data_valid),
      .mem_enable       (mem_enable),
      .mem_wr           (mem_wr),
      .mem_addr         (mem_addr),
      .mem_data_in      (mem_data_in),
      .mem_data_valid   (mem_data_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: sample mid-cycle, score memory accesses, then advance to
   // just after the next rising edge and drive the memory model's return.
   task automatic tick();
      acc_t e;
      #4;
      s_igrant = icache_grant;
      s_dgrant = dcache_grant;
      s_done   = dcache_wr_done;
      s_wr     = mem_wr;
      s_ival   = icache_data_valid;
      s_dval   = dcache_data_valid;
      s_vec    = {icache_grant, dcache_grant, dcache_wr_done, icache_data_valid,
                  dcache_data_valid, mem_enable, mem_wr, mem_addr, mem_data_in};
      if (mem_enable) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_access", {63'h0, mem_enable}, 64'h0);
         end else begin
            e = exp_q.pop_front();
            chk("access", {31'h0, mem_wr, mem_addr, (e.wr ? mem_data_in : 16'h0)},
                {31'h0, e.wr, e.addr, e.data});
         end
         if (!mem_wr) ret_q.push_back(cyc + LAT);
      end
      if (icache_data_valid) begin
         n_valid[0]++;
         if (beat_first[0] < 0) beat_first[0] = cyc;
         beat_last[0] = cyc;
      end
      if (dcache_data_valid) begin
         n_valid[1]++;
         if (beat_first[1] < 0) beat_first[1] = cyc;
         beat_last[1] = cyc;
      end
      if (dcache_wr_done) n_wr_done++;
      @(posedge clk);
      #1;
      cyc++;
      mem_data_valid = 1'b0;
      if (ret_q.size() != 0 && ret_q[0] == cyc) begin
         void'(ret_q.pop_front());
         mem_data_valid = 1'b1;
      end
   endtask

   // Expects the fill to own memory from the current cycle onwards.
   task automatic do_fill(input bit side, input logic [15:0] base, input int wr_at);
      int   start, cnt, n0, n1;
      acc_t e;
      start = cyc;
      n0 = n_valid[side];
      n1 = n_valid[!side];
      beat_first[side] = -1;
      beat_last[side]  = -1;
      for (int k = 0; k < 8; k++) begin
         logic [15:0] a;
         a = base + 16'(2 * k);
         if (side) dcache_addr = a; else icache_addr = a;
         if (k == wr_at) begin
            dcache_wr      = 1'b1;
            dcache_wr_addr = 16'h00F0;
            dcache_wr_data = 16'hBEEF;
         end
         e.wr = 1'b0; e.addr = a; e.data = 16'h0;
         exp_q.push_back(e);
         tick();
         if (k == 0) chk("fill_grant", {62'h0, s_igrant, s_dgrant}, side ? 64'h1 : 64'h2);
         if (k == 2) begin
            if (side) dcache_miss = 1'b0; else icache_miss = 1'b0;
         end
      end
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while ((side ? s_dgrant : s_igrant) && cnt < 20);
      chk("fill_tail_cycles", cnt, 5);
      chk("fill_owner_beats", n_valid[side] - n0, 8);
      chk("fill_other_beats", n_valid[!side] - n1, 0);
      chk("fill_first_beat", beat_first[side], start + LAT);
      chk("fill_last_beat", beat_last[side], start + 7 + LAT);
      last_d = side;
   endtask

   task automatic pair_fill(input logic [15:0] ibase, input logic [15:0] dbase);
      bit first_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      first_d = !last_d;
`else
      first_d = 1'b1;
`endif
      icache_miss = 1'b1;
      dcache_miss = 1'b1;
      tick();
      chk("pair_idle_grant", {62'h0, s_igrant, s_dgrant}, 64'h0);
      do_fill(first_d, first_d ? dbase : ibase, -1);
      do_fill(!first_d, first_d ? ibase : dbase, -1);
   endtask

   initial begin
      acc_t e;
      int   bad, n0, n1, nd;
      rst = 1'b1;
      icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr = 1'b0; mem_data_valid = 1'b0;
      icache_addr = 16'h0; dcache_addr = 16'h0; dcache_wr_addr = 16'h0; dcache_wr_data = 16'h0;
      n_valid = '{0, 0}; beat_first = '{-1, -1}; beat_last = '{-1, -1};
      @(posedge clk);
      #1;

      // Reset with an I-cache miss already pending
      icache_miss = 1'b1;
      icache_addr = 16'h4000;
      tick();
      tick();
      chk("reset_outputs", {25'h0, s_vec}, 64'h0);
      rst = 1'b0;
      bad = 0;
      repeat (5) begin
         tick();
         bad += int'(s_igrant | s_dgrant);
      end
      chk("drain_no_grant", bad, 0);
      do_fill(1'b0, 16'h4000, -1);

      // D-cache fill alone
      dcache_miss = 1'b1;
      tick();
      chk("dreq_idle_grant", {62'h0, s_igrant, s_dgrant}, 64'h0);
      do_fill(1'b1, 16'h1230, -1);

      // Simultaneous misses, twice
      pair_fill(16'h2000, 16'h3000);
      pair_fill(16'h2100, 16'h3100);

      // Store from IDLE
      dcache_wr = 1'b1; dcache_wr_addr = 16'h0ABC; dcache_wr_data = 16'h1234;
      e.wr = 1'b1; e.addr = 16'h0ABC; e.data = 16'h1234;
      exp_q.push_back(e);
      tick();
      chk("store_idle_no_done", s_done, 1'b0);
      dcache_wr = 1'b0;
      tick();
      chk("store_done_next", s_done, 1'b1);

      // Store arriving during an I-cache fill
      icache_miss = 1'b1;
      tick();
      nd = n_wr_done;
      do_fill(1'b0, 16'h5000, 3);
      chk("store_held_in_fill", n_wr_done - nd, 0);
      e.wr = 1'b1; e.addr = 16'h00F0; e.data = 16'hBEEF;
      exp_q.push_back(e);
      tick();
      chk("store_after_fill_done", s_done, 1'b1);
      chk("store_after_fill_wr", s_wr, 1'b1);
      dcache_wr = 1'b0;

      // Reset after three issued reads of a D-cache fill
      dcache_miss = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         dcache_addr = 16'h6000 + 16'(2 * k);
         e.wr = 1'b0; e.addr = dcache_addr; e.data = 16'h0;
         exp_q.push_back(e);
         if (k == 2) begin
            rst = 1'b1;
            dcache_miss = 1'b0;
         end
         tick();
      end
      rst = 1'b0;
      last_d = 1'b0;
      icache_miss = 1'b1;
      icache_addr = 16'h7000;
      n0 = n_valid[0];
      n1 = n_valid[1];
      tick();
      chk("rst_grant_next", {62'h0, s_igrant, s_dgrant}, 64'h0);
      bad = 0;
      repeat (4) begin
         tick();
         bad += int'(s_igrant | s_dgrant);
      end
      chk("rst_drain_no_grant", bad, 0);
      chk("rst_stale_beats", (n_valid[0] - n0) + (n_valid[1] - n1), 0);
      do_fill(1'b0, 16'h7000, -1);

      // Stray return while IDLE
      mem_data_valid = 1'b1;
      tick();
      chk("idle_beat_unrouted", {62'h0, s_ival, s_dval}, 64'h0);
      tick();

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single shared 4-cycle pipelined main memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. Sits directly between the per-cache fill FSMs and the memory model. Holds a grant for a full 8-chunk block fill and routes returning `mem_data_valid` beats only to the granted cache. Serialises stores against fills and masks stale returns after reset.

## Interface
- `MEM_LATENCY`, 4: cycles from `mem_enable` (read) to matching `mem_data_valid`
- `CHUNKS`, 8: 2-byte chunks per cache block (16-byte block)

- `clk` in 1: clock, all state updates on rising edge
- `rst` in 1: synchronous reset, active-high
- `icache_miss` in 1: I-cache fill FSM busy / requesting
- `icache_addr` in 16: I-cache chunk address
- `dcache_miss` in 1: D-cache fill FSM busy / requesting
- `dcache_addr` in 16: D-cache chunk address
- `dcache_wr` in 1: D-cache write-through store request
- `dcache_wr_addr` in 16: store address
- `dcache_wr_data` in 16: store data
- `icache_grant` out 1: I-cache owns memory
- `dcache_grant` out 1: D-cache fill owns memory
- `dcache_wr_done` out 1: one-cycle pulse, store written
- `icache_data_valid` out 1: routed valid for I-cache
- `dcache_data_valid` out 1: routed valid for D-cache
- `mem_enable` out 1: memory access strobe
- `mem_wr` out 1: 1 = write, 0 = read
- `mem_addr` out 16: memory address
- `mem_data_in` out 16: memory write data
- `mem_data_valid` in 1: memory read data valid

## Operation
- States: DRAIN, IDLE, IFILL, DFILL, DWRITE. Registers: state, `issued` (0..CHUNKS), `returned` (0..CHUNKS), drain counter.
- DRAIN: entered on reset; held MEM_LATENCY cycles; no grants; `mem_data_valid` ignored; then IDLE.
- IDLE choice, fixed priority: `dcache_wr` → DWRITE; else `dcache_miss` → DFILL; else `icache_miss` → IFILL.
- DWRITE: exactly one cycle, `mem_enable`=1, `mem_wr`=1, `mem_addr`=`dcache_wr_addr`, `mem_data_in`=`dcache_wr_data`, `dcache_wr_done`=1; → IDLE.
- IFILL/DFILL: grant asserted; `mem_enable`=1, `mem_wr`=0, `mem_addr`=granted side's address while `issued` < CHUNKS; `issued`++ each such cycle. Each `mem_data_valid` increments `returned` and drives the granted side's `*_data_valid` in the same cycle (combinational).
- Fill ends in the cycle where `returned` reaches CHUNKS; next state IDLE, counters cleared.
- Stores arriving during a fill wait; `dcache_wr_done` is their only acknowledgement.
- `mem_data_valid` in IDLE/DWRITE/DRAIN is never routed.
- Requester dropping its miss mid-fill: ignored, fill completes.
- Counter widths: $clog2(CHUNKS+1); saturate, never wrap.

## Timing
- Reset values: all outputs 0, state DRAIN, counters 0.
- Request seen in IDLE at cycle N → grant/`mem_enable` from cycle N+1 (registered state).
- Fill at defaults: issues N+1..N+8, returns N+5..N+12, grant low from N+13; next arbitration decided in cycle N+13.
- Store in IDLE at cycle N → write and `dcache_wr_done` at N+1.
- `mem_enable` never asserted in IDLE or DRAIN.
- `rst` mid-fill: next cycle DRAIN, grants 0, in-flight returns masked.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined: when `icache_miss` and `dcache_miss` are both pending in IDLE (no store), grant goes to the side not served by the last fill; a last-served bit resets to "I-cache" so D-cache wins first. Stores still have top priority.
- Not defined: fixed priority above, D-cache fill always beats I-cache.

## Structure
- Shared package `cache_pkg`: `arb_state_t` enum, `CACHE_CHUNKS`, `MEM_LATENCY` constants, 16-bit address typedef.
- One sub-module: `fill_beat_counter` (issue/return counting with saturation and done flag), instantiated once.

## Test plan
- Reset, `icache_miss`=1 immediately → no grant for 4 DRAIN cycles, then grant and 8 reads from `icache_addr` values.
- `dcache_miss` at cycle N, addr 0x1230..0x123E → `mem_enable` N+1..N+8, 8 `dcache_data_valid` N+5..N+12, grant low N+13.
- Both misses together in IDLE → D-cache filled first, I-cache granted at fill end + 1; with macro, a second simultaneous pair goes to I-cache.
- `dcache_wr` (0x00F0, 0xBEEF) during I-cache fill → no write until fill ends; then `mem_wr`=1 with those values and `dcache_wr_done` pulse.
- `rst` after 3 issued reads → grant 0 next cycle, stale `mem_data_valid` beats not routed, no grant for 4 cycles.
- `mem_data_valid` injected in IDLE → neither routed valid asserts.
